tail_light_seq: RTL and testbench
=================================

# tail_light_seq

Parametrised sequential turn-signal and hazard controller for a pair of lamp banks. It generalises the fixed three-lamp left/right taillight sequencer with configurable lamp count and step rate, explicit hazard mode with priority rules, and an optional brake overlay. It sits between debounced driver switch inputs and the lamp driver outputs.

## Interface
- LAMPS, 3, lamps per side (≥1); bit 0 is innermost
- DIV, 4, clk cycles per sequence step (≥1; 1 = step every cycle)
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- left  input  1  left turn request, level
- right  input  1  right turn request, level
- hazard  input  1  hazard request, level
- brake  input  1  brake pedal, level (present only with TAIL_BRAKE_EN)
- lamps_l  output  LAMPS  left bank, 1 = lit
- lamps_r  output  LAMPS  right bank, 1 = lit
- busy  output  1  high whenever state ≠ IDLE

## Operation
- Prescaler counts 0..DIV-1 and wraps; tick = (count == DIV-1). State, step and lamps change only on tick cycles.
- Effective request priority: hazard, or left&right together → HAZ; else left → LEFT; else right → RIGHT; else none.
- States: IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF.
- IDLE on tick: HAZ request → HAZ_ON; LEFT → LEFT with step=1; RIGHT → RIGHT with step=1; none → stay.
- LEFT/RIGHT: active bank shows lamps[step-1:0] lit (thermometer from bit 0); other bank dark. On tick, step increments 1..LAMPS, then goes to 0 (all dark). At step 0 the tick is evaluated exactly as in IDLE.
- A HAZ request on any tick in LEFT/RIGHT preempts immediately → HAZ_ON.
- Deassertion of the turn input, or a change of direction mid-sequence, is ignored until step 0; the sequence always completes.
- HAZ_ON: both banks fully lit; tick → HAZ_OFF. HAZ_OFF: both dark; on tick, HAZ request still present → HAZ_ON, otherwise evaluate as IDLE.
- Step counter width $clog2(LAMPS+1); no overflow past LAMPS.

## Timing
- All outputs registered; lamps update in the cycle after the tick edge.
- Reset (any time, including mid-sequence): state IDLE, step 0, prescaler 0, lamps_l = lamps_r = 0, busy 0. First tick occurs DIV cycles after reset release.
- Request-to-first-lamp latency: 1..DIV cycles, depending on prescaler phase. Inputs are sampled only on tick; pulses shorter than DIV may be missed.
- Full turn period: (LAMPS+1)·DIV cycles. Hazard blink period: 2·DIV cycles.

## Configuration
- TAIL_BRAKE_EN defined: brake port exists. While brake=1, any bank that is not currently sequencing is forced fully lit (both banks in IDLE; the opposite bank in LEFT/RIGHT). Brake has no effect in HAZ_ON/HAZ_OFF. Overlay is applied combinationally before the output register, so it is visible one cycle after brake changes, independent of tick.
- Undefined: no brake port; behaviour as in Operation.

## Structure
- Package tail_light_pkg: state enum typedef (IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF) and request-priority encoding.
- Sub-module tick_prescaler (parameter DIV; outputs a one-cycle tick); the FSM and lamp decode live in tail_light_seq.

## Test plan
- Reset then left=1 held, LAMPS=3, DIV=4 → lamps_l per tick: 001, 011, 111, 000, 001…; lamps_r stays 000; busy=1.
- Left pulsed for one full tick then released → one full sequence 001, 011, 111, 000, then IDLE, busy=0.
- Right sequencing at step 2, hazard asserted → at next tick both banks 111, then 000 alternating every 4 cycles; hazard released during HAZ_ON → one HAZ_OFF, then IDLE.
- left=right=1 from IDLE → hazard pattern identical to hazard=1; left switched to right at step 1 → left sequence completes, then right starts at step 1.
- Reset asserted mid-sequence (lamps_l=011) → outputs 000 asynchronously; after release, first change only after 4 cycles.
- With TAIL_BRAKE_EN: brake=1 in IDLE → both 111 next cycle; brake=1 during left sequence → lamps_r=111, lamps_l sequences normally; brake during hazard → pattern unchanged.

Source files
------------

// File: rtl/tail_light_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_pkg
// Description : Shared types for the tail light sequencer: FSM state
//               encoding and the prioritised driver-request encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tail_light_pkg;

  // Sequencer states; LEFT/RIGHT carry a step count alongside the state.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEFT    = 3'd1,
    RIGHT   = 3'd2,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4
  } state_t;

  // Effective request after priority resolution.
  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LEFT  = 2'd1,
    REQ_RIGHT = 2'd2,
    REQ_HAZ   = 2'd3
  } req_t;

  // Hazard wins, and both turn switches together also mean hazard.
  function automatic req_t encode_req(input logic left, input logic right,
                                      input logic hazard);
    req_t req;
    req = REQ_NONE;
    if (hazard || (left && right)) begin
      req = REQ_HAZ;
    end else if (left) begin
      req = REQ_LEFT;
    end else if (right) begin
      req = REQ_RIGHT;
    end
    return req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tail_light_seq_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running 0..DIV-1 counter producing a one-cycle tick on
//               the terminal count. DIV=1 ticks every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  generate
    if (DIV > 1) begin : g_count
      localparam int CW = $clog2(DIV);
      localparam logic [CW-1:0] c_last = CW'(DIV - 1);

      logic [CW-1:0] r_count;

      // Wrapping step counter; restarts from zero on reset.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_count <= '0;
        end else if (r_count == c_last) begin
          r_count <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end

      assign tick = (r_count == c_last);
    end else begin : g_every_cycle
      assign tick = 1'b1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/tail_light_seq.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_seq
// Description : Sequential turn-signal / hazard controller for two lamp
//               banks. Optional brake overlay enabled by TAIL_BRAKE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int LAMPS = 3,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
`ifdef TAIL_BRAKE_EN
  input  logic             brake,
`endif
  output logic [LAMPS-1:0] lamps_l,
  output logic [LAMPS-1:0] lamps_r,
  output logic             busy
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] c_step_max = SW'(LAMPS);
  localparam logic [SW-1:0] c_step_one = SW'(1);

  logic             w_tick;
  logic             w_brake;
  req_t             w_req;
  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_eval_state;
  logic [SW-1:0]    r_step;
  logic [SW-1:0]    w_step_nxt;
  logic [SW-1:0]    w_eval_step;
  logic [LAMPS-1:0] w_therm;
  logic [LAMPS-1:0] w_lamps_l_nxt;
  logic [LAMPS-1:0] w_lamps_r_nxt;
  logic [LAMPS-1:0] r_lamps_l;
  logic [LAMPS-1:0] r_lamps_r;
  logic             r_busy;

`ifdef TAIL_BRAKE_EN
  assign w_brake = brake;
`else
  assign w_brake = 1'b0;
`endif

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_req = encode_req(left, right, hazard);

  // Decision taken from rest (IDLE, HAZ_OFF, or a finished turn at step 0).
  always_comb begin
    w_eval_state = IDLE;
    w_eval_step  = '0;
    case (w_req)
      REQ_HAZ:   w_eval_state = HAZ_ON;
      REQ_LEFT:  begin w_eval_state = LEFT;  w_eval_step = c_step_one; end
      REQ_RIGHT: begin w_eval_state = RIGHT; w_eval_step = c_step_one; end
      default:   ;
    endcase
  end

  // Next state/step; everything holds except on tick cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    if (w_tick) begin
      case (r_state)
        IDLE, HAZ_OFF: begin
          w_state_nxt = w_eval_state;
          w_step_nxt  = w_eval_step;
        end
        LEFT, RIGHT: begin
          if (w_req == REQ_HAZ) begin
            w_state_nxt = HAZ_ON;
            w_step_nxt  = '0;
          end else if (r_step == c_step_max) begin
            w_step_nxt = '0;
          end else if (r_step != '0) begin
            w_step_nxt = r_step + 1'b1;
          end else begin
            // A turn only ends or changes direction once it reaches step 0.
            w_state_nxt = w_eval_state;
            w_step_nxt  = w_eval_step;
          end
        end
        HAZ_ON: begin
          w_state_nxt = HAZ_OFF;
          w_step_nxt  = '0;
        end
        default: begin
          w_state_nxt = IDLE;
          w_step_nxt  = '0;
        end
      endcase
    end
  end

  // Lamp decode of the upcoming state, with brake lighting any idle bank.
  always_comb begin
    w_therm = '0;
    for (int i = 0; i < LAMPS; i++) begin
      w_therm[i] = (i < int'(w_step_nxt));
    end
    w_lamps_l_nxt = w_brake ? '1 : '0;
    w_lamps_r_nxt = w_brake ? '1 : '0;
    case (w_state_nxt)
      LEFT:    w_lamps_l_nxt = w_therm;
      RIGHT:   w_lamps_r_nxt = w_therm;
      HAZ_ON:  begin w_lamps_l_nxt = '1; w_lamps_r_nxt = '1; end
      HAZ_OFF: begin w_lamps_l_nxt = '0; w_lamps_r_nxt = '0; end
      default: ;
    endcase
  end

  // State and registered outputs; outputs refresh every cycle so the brake
  // overlay does not wait for a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_lamps_l <= '0;
      r_lamps_r <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_lamps_l <= w_lamps_l_nxt;
      r_lamps_r <= w_lamps_r_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign lamps_l = r_lamps_l;
  assign lamps_r = r_lamps_r;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tail_light_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tail_light_seq
// Description : Scoreboard bench for tail_light_seq (LAMPS=3, DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tail_light_seq;

  localparam int LAMPS = 3;
  localparam int DIV   = 4;
  localparam int OW    = 2 * LAMPS + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             left, right, hazard, brake;
  logic [LAMPS-1:0] lamps_l, lamps_r;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [OW-1:0] exp_q[$];

  // Reference model: mode 0 idle, 1 left, 2 right, 3 hazard on, 4 hazard off
  int m_cnt, m_mode, m_pos;

  always #5 clk = ~clk;

  tail_light_seq #(.LAMPS(LAMPS), .DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .left    (left),
    .right   (right),
    .hazard  (hazard),
`ifdef TAIL_BRAKE_EN
    .brake   (brake),
`endif
    .lamps_l (lamps_l),
    .lamps_r (lamps_r),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_mode = 0; m_pos = 0;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  function automatic void model_step();
    bit tk, hz, rest;
    tk = (m_cnt == DIV - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    if (tk) begin
      hz   = hazard || (left && right);
      rest = (m_mode == 0) || (m_mode == 4) || ((m_mode == 1 || m_mode == 2) && m_pos == 0);
      if (m_mode == 3) begin
        m_mode = 4; m_pos = 0;
      end else if (hz) begin
        m_mode = 3; m_pos = 0;
      end else if (rest) begin
        if (left)       begin m_mode = 1; m_pos = 1; end
        else if (right) begin m_mode = 2; m_pos = 1; end
        else            begin m_mode = 0; m_pos = 0; end
      end else begin
        m_pos = (m_pos == LAMPS) ? 0 : m_pos + 1;
      end
    end
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [LAMPS-1:0] full, th, l, r, side;
    logic b;
`ifdef TAIL_BRAKE_EN
    b = brake;
`else
    b = 1'b0;
`endif
    full = '1;
    th   = LAMPS'((1 << m_pos) - 1);
    side = b ? full : '0;
    l = '0; r = '0;
    case (m_mode)
      0: begin l = side; r = side; end
      1: begin l = th;   r = side; end
      2: begin l = side; r = th;   end
      3: begin l = full; r = full; end
      default: ;
    endcase
    return {(m_mode != 0), l, r};
  endfunction

  // One clock: predict, push, wait for the edge, pop and compare.
  task automatic cyc(input string tag);
    logic [OW-1:0] e;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, {busy, lamps_l, lamps_r}, e);
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  // Reset mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("async_rst", {busy, lamps_l, lamps_r}, 0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LAMPS-1:0] tbl[5];
    int n;
    tbl[0] = 3'b001; tbl[1] = 3'b011; tbl[2] = 3'b111; tbl[3] = 3'b000; tbl[4] = 3'b001;
    left = 0; right = 0; hazard = 0; brake = 0;
    reset = 1'b1;
    model_reset();
    #12;
    check("reset_state", {busy, lamps_l, lamps_r}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Left held: thermometer per tick, wrapping through dark.
    left = 1;
    for (int k = 0; k < 5; k++) begin
      cycles(DIV, "left_hold");
      check("left_seq", lamps_l, tbl[k]);
      check("left_r_dark", lamps_r, 0);
    end

    // Left for one tick only: sequence completes then idles.
    do_reset();
    left = 1;
    cycles(DIV, "pulse");
    left = 0;
    cycles(3 * DIV, "pulse");
    cycles(DIV, "pulse");
    check("pulse_idle", busy, 0);

    // Right to step 2, then hazard preempts.
    right = 1;
    cycles(2 * DIV, "right");
    check("right_step2", lamps_r, 3'b011);
    hazard = 1; right = 0;
    cycles(DIV, "haz");
    check("haz_on", {lamps_l, lamps_r}, 6'b111111);
    cycles(DIV, "haz");
    check("haz_off", {lamps_l, lamps_r}, 6'b000000);
    cycles(DIV, "haz");
    hazard = 0;
    cycles(DIV, "haz_rel");
    cycles(DIV, "haz_rel");
    check("haz_idle", busy, 0);

    // Both turn switches behave as hazard.
    left = 1; right = 1;
    cycles(DIV, "lr_haz");
    check("lr_haz_on", {lamps_l, lamps_r}, 6'b111111);
    cycles(DIV, "lr_haz");
    left = 0; right = 0;
    cycles(2 * DIV, "lr_rel");

    // Direction change mid-sequence is deferred until step 0.
    left = 1;
    cycles(DIV, "dir");
    left = 0; right = 1;
    cycles(2 * DIV, "dir");
    check("dir_left_done", lamps_l, 3'b111);
    cycles(2 * DIV, "dir");
    check("dir_right_start", lamps_r, 3'b001);
    right = 0;

    // Reset mid-sequence, then first change DIV cycles after release.
    do_reset();
    left = 1;
    cycles(2 * DIV, "pre_rst");
    check("pre_rst_l", lamps_l, 3'b011);
    do_reset();
    n = 0;
    while (lamps_l == 0 && n < 20) begin
      cyc("post_rst");
      n++;
    end
    check("first_change", n, DIV);
    left = 0;

`ifdef TAIL_BRAKE_EN
    do_reset();
    brake = 1;
    cyc("brake_idle");
    check("brake_idle", {lamps_l, lamps_r}, 6'b111111);
    cycles(DIV - 1, "brake_idle");
    left = 1;
    cycles(DIV, "brake_left");
    check("brake_left", {lamps_l, lamps_r}, 6'b001111);
    cycles(DIV, "brake_left");
    hazard = 1;
    cycles(2 * DIV, "brake_haz");
    hazard = 0; left = 0; brake = 0;
`endif

    // Randomised input runs held for random durations.
    do_reset();
    for (int t = 0; t < 60; t++) begin
      left   = $urandom_range(0, 1);
      right  = $urandom_range(0, 1);
      hazard = ($urandom_range(0, 4) == 0);
`ifdef TAIL_BRAKE_EN
      brake  = $urandom_range(0, 1);
`endif
      cycles($urandom_range(1, 12), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
